// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane strobe helper
// used by the SRAM responder.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_DWORD = 3'd3,
        SZ_4W    = 3'd4,
        SZ_8W    = 3'd5,
        SZ_16W   = 3'd6,
        SZ_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian lane mask; sizes above a word never reach a write commit.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr;
            SZ_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side signal group (*_S) shared between the master agent and the
// SRAM responder.
interface ahb_sram_slave_if;
    logic        HSEL_S;
    logic        HREADY_S;
    logic [1:0]  HTRANS_S;
    logic [2:0]  HBURST_S;
    logic [2:0]  HSIZE_S;
    logic        HWRITE_S;
    logic [31:0] HADDR_S;
    logic [31:0] HWDATA_S;
    logic        HREADYOUT_S;
    logic [1:0]  HRESP_S;
    logic [31:0] HRDATA_S;

    modport master (
        output HSEL_S, HREADY_S, HTRANS_S, HBURST_S, HSIZE_S, HWRITE_S, HADDR_S, HWDATA_S,
        input  HREADYOUT_S, HRESP_S, HRDATA_S
    );

    modport slave (
        input  HSEL_S, HREADY_S, HTRANS_S, HBURST_S, HSIZE_S, HWRITE_S, HADDR_S, HWDATA_S,
        output HREADYOUT_S, HRESP_S, HRDATA_S
    );
endinterface

// File: rtl/ahb_sram_bytelane.sv
// Word-organised flop array with per-byte write strobes and an asynchronous
// read port. Contents are deliberately not reset.
module ahb_sram_bytelane #(
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       strobe,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: fixed wait-state OKAY transfers, two-cycle ERROR for
// out-of-window, oversized or misaligned accesses; never RETRY/SPLIT.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             HCLK_S,
    input logic             HRESETn,
    ahb_sram_slave_if.slave bus
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    slave_state_e     state, state_next;
    logic [3:0]       wait_cnt, wait_cnt_next;
    logic             ready_q;
    hresp_e           resp_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       size_q;
    logic [1:0]       lane_q;
    logic             write_q;

    logic [31:0] offset;
    logic        accept;
    logic        addr_err;
    logic [31:0] mem_word;

    // An address below the base wraps to a huge offset, so one compare covers both ends.
    assign offset = bus.HADDR_S - BASE_ADDR;
    assign accept = bus.HSEL_S && bus.HREADY_S &&
                    (bus.HTRANS_S == HT_NONSEQ || bus.HTRANS_S == HT_SEQ);

    always_comb begin
        addr_err = (offset >= WIN_BYTES)
                || (bus.HSIZE_S > SZ_WORD)
                || (bus.HSIZE_S == SZ_HALF && bus.HADDR_S[0] != 1'b0)
                || (bus.HSIZE_S == SZ_WORD && bus.HADDR_S[1:0] != 2'b00);
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = S_DATA;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WS_LOAD;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next    = S_DATA;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the data phase.
    always_ff @(posedge HCLK_S or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ready_q  <= 1'b1;
            resp_q   <= RESP_OKAY;
            idx_q    <= '0;
            size_q   <= 3'd0;
            lane_q   <= 2'd0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ready_q  <= !(state_next == S_WAIT || state_next == S_ERR1);
            resp_q   <= (state_next == S_ERR1 || state_next == S_ERR2) ? RESP_ERROR : RESP_OKAY;
            if (accept) begin
                idx_q   <= offset[IDX_W+1:2];
                size_q  <= bus.HSIZE_S;
                lane_q  <= bus.HADDR_S[1:0];
                write_q <= bus.HWRITE_S;
            end
        end
    end

    ahb_sram_bytelane #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk    (HCLK_S),
        .we     (state == S_DATA && write_q),
        .strobe (byte_strobe(size_q, lane_q)),
        .idx    (idx_q),
        .wdata  (bus.HWDATA_S),
        .rdata  (mem_word)
    );

    assign bus.HREADYOUT_S = ready_q;
    assign bus.HRESP_S     = resp_q;
    assign bus.HRDATA_S    = (state == S_DATA) ? mem_word : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with one wait state, one with none,
// sharing a bus whose target is selected by tgt.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tgt = 1'b0;
    logic        hsel = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hburst = 3'd0;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic        hready;
    logic [1:0]  resp;
    logic [31:0] rdata;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_if if0 ();
    ahb_sram_slave_if if1 ();

    assign if0.HSEL_S   = hsel & ~tgt;
    assign if1.HSEL_S   = hsel & tgt;
    assign if0.HREADY_S = hready;
    assign if1.HREADY_S = hready;
    assign if0.HTRANS_S = htrans;
    assign if1.HTRANS_S = htrans;
    assign if0.HBURST_S = hburst;
    assign if1.HBURST_S = hburst;
    assign if0.HSIZE_S  = hsize;
    assign if1.HSIZE_S  = hsize;
    assign if0.HWRITE_S = hwrite;
    assign if1.HWRITE_S = hwrite;
    assign if0.HADDR_S  = haddr;
    assign if1.HADDR_S  = haddr;
    assign if0.HWDATA_S = hwdata;
    assign if1.HWDATA_S = hwdata;

    assign hready = tgt ? if1.HREADYOUT_S : if0.HREADYOUT_S;
    assign resp   = tgt ? if1.HRESP_S     : if0.HRESP_S;
    assign rdata  = tgt ? if1.HRDATA_S    : if0.HRDATA_S;

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .HCLK_S(clk), .HRESETn(rst_n), .bus(if0.slave)
    );

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .HCLK_S(clk), .HRESETn(rst_n), .bus(if1.slave)
    );

    typedef struct {
        bit          tgt;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit t, input bit w, input logic [2:0] s, input logic [31:0] a,
                                input logic [31:0] wd, input bit e, input logic [31:0] rd,
                                input string n);
        vec_t v;
        v.tgt = t; v.wr = w; v.size = s; v.addr = a; v.wdata = wd;
        v.err = e; v.rdata = rd; v.name = n;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Single non-pipelined transfer; data-phase cycles are sampled on the falling edge.
    task automatic xfer(input vec_t v);
        int          cyc;
        int          exp_lat;
        logic        r0, rn;
        logic [1:0]  resp0, respn;
        logic [31:0] rd;
        tgt = v.tgt;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'd2; hburst = 3'd0;
        hwrite = v.wr; hsize = v.size; haddr = v.addr;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = v.wdata;
        cyc = 0; r0 = 1'b0; resp0 = 2'd0; rn = 1'b0; respn = 2'd0; rd = 32'h0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                r0 = hready;
                resp0 = resp;
            end
            rn = hready;
            respn = resp;
            rd = rdata;
        end while (!rn && cyc < 20);
        exp_lat = v.err ? 2 : (v.tgt ? 1 : 2);
        check({v.name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({v.name, " first readyout"}, {31'h0, r0}, (v.err || !v.tgt) ? 32'h0 : 32'h1);
        check({v.name, " resp"}, {30'h0, respn}, v.err ? 32'h1 : 32'h0);
        if (v.err) begin
            check({v.name, " first resp"}, {30'h0, resp0}, 32'h1);
            check({v.name, " rdata"}, rd, 32'h0);
        end else if (!v.wr) begin
            check({v.name, " rdata"}, rd, v.rdata);
        end
    endtask

    initial begin
        logic [31:0] d [4];
        logic [1:0]  idle_trans [3];
        logic        idle_sel [3];

        d[0] = 32'hA0A0_A0A0; d[1] = 32'h1B1B_1B1B; d[2] = 32'h2C2C_2C2C; d[3] = 32'h3D3D_3D3D;
        idle_trans[0] = 2'd0; idle_trans[1] = 2'd1; idle_trans[2] = 2'd2;
        idle_sel[0] = 1'b1;   idle_sel[1] = 1'b1;   idle_sel[2] = 1'b0;

        vecs.push_back(mk(0, 1, 3'd2, 32'h10,  32'hDEAD_BEEF, 0, 32'h0,         "w word 0x10"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h10,  32'h0,         0, 32'hDEAD_BEEF, "r word 0x10"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h20,  32'h1122_3344, 0, 32'h0,         "w word 0x20"));
        vecs.push_back(mk(0, 1, 3'd0, 32'h21,  32'h5555_AA55, 0, 32'h0,         "w byte 0x21"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h20,  32'h0,         0, 32'h1122_AA44, "r after byte"));
        vecs.push_back(mk(0, 1, 3'd1, 32'h22,  32'hBEEF_1234, 0, 32'h0,         "w half 0x22"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h20,  32'h0,         0, 32'hBEEF_AA44, "r after half hi"));
        vecs.push_back(mk(0, 1, 3'd1, 32'h20,  32'h0000_7777, 0, 32'h0,         "w half 0x20"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h20,  32'h0,         0, 32'hBEEF_7777, "r after half lo"));
        vecs.push_back(mk(0, 1, 3'd0, 32'h23,  32'h9900_0000, 0, 32'h0,         "w byte 0x23"));
        vecs.push_back(mk(0, 0, 3'd0, 32'h23,  32'h0,         0, 32'h99EF_7777, "r byte 0x23"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h402, 32'hFFFF_FFFF, 1, 32'h0,         "w misaligned 0x402"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h400, 32'h0,         1, 32'h0,         "r out of range 0x400"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h12,  32'h0,         1, 32'h0,         "w word misaligned 0x12"));
        vecs.push_back(mk(0, 1, 3'd1, 32'h11,  32'h0,         1, 32'h0,         "w half odd 0x11"));
        vecs.push_back(mk(0, 1, 3'd3, 32'h10,  32'h0,         1, 32'h0,         "w oversized 0x10"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h10,  32'h0,         0, 32'hDEAD_BEEF, "r 0x10 unchanged"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0,   32'hCAFE_F00D, 0, 32'h0,         "w word 0x0"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h400, 32'h0,         1, 32'h0,         "w out of range 0x400"));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0,   32'h0,         0, 32'hCAFE_F00D, "r 0x0 unchanged"));
        vecs.push_back(mk(0, 1, 3'd2, 32'h30,  32'h0BAD_F00D, 0, 32'h0,         "w word 0x30"));
        vecs.push_back(mk(1, 1, 3'd2, 32'h10,  32'h1357_9BDF, 0, 32'h0,         "ws0 w word 0x10"));
        vecs.push_back(mk(1, 0, 3'd2, 32'h10,  32'h0,         0, 32'h1357_9BDF, "ws0 r word 0x10"));
        vecs.push_back(mk(1, 0, 3'd2, 32'h400, 32'h0,         1, 32'h0,         "ws0 r out of range"));

        repeat (3) @(posedge clk);
        #1;
        check("reset ws1 readyout", {31'h0, if0.HREADYOUT_S}, 32'h1);
        check("reset ws1 resp",     {30'h0, if0.HRESP_S},     32'h0);
        check("reset ws1 rdata",    if0.HRDATA_S,             32'h0);
        check("reset ws0 readyout", {31'h0, if1.HREADYOUT_S}, 32'h1);
        check("reset ws0 resp",     {30'h0, if1.HRESP_S},     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) xfer(vecs[i]);

        // IDLE and BUSY while selected, then an unselected NONSEQ write.
        tgt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hsel = idle_sel[k]; htrans = idle_trans[k];
            hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
            @(posedge clk);
            #1;
            hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0;
            @(negedge clk);
            check($sformatf("no-op %0d readyout", k), {31'h0, hready}, 32'h1);
            check($sformatf("no-op %0d resp", k), {30'h0, resp}, 32'h0);
        end
        xfer(mk(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, "r 0x10 after no-ops"));

        // Reset asserted while a write to 0x30 sits in its wait state.
        tgt = 1'b0;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h1234_5678;
        check("wait before reset readyout", {31'h0, if0.HREADYOUT_S}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset readyout", {31'h0, if0.HREADYOUT_S}, 32'h1);
        check("mid reset resp",     {30'h0, if0.HRESP_S},     32'h0);
        check("mid reset rdata",    if0.HRDATA_S,             32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(mk(0, 0, 3'd2, 32'h30, 32'h0, 0, 32'h0BAD_F00D, "r 0x30 after reset"));

        // Zero-wait INCR4 writes then reads, fully pipelined.
        tgt = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("incr4 w%0d readyout", i - 1), {31'h0, hready}, 32'h1);
                check($sformatf("incr4 w%0d resp", i - 1), {30'h0, resp}, 32'h0);
                hwdata = d[i-1];
            end
            if (i < 4) begin
                hsel = 1'b1; htrans = (i == 0) ? 2'd2 : 2'd3; hburst = 3'd3;
                hwrite = 1'b1; hsize = 3'd2; haddr = 32'(4 * i);
            end else begin
                hsel = 1'b0; htrans = 2'd0; hburst = 3'd0;
            end
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("incr4 r%0d readyout", i - 1), {31'h0, hready}, 32'h1);
                check($sformatf("incr4 r%0d rdata", i - 1), rdata, d[i-1]);
            end
            if (i < 4) begin
                hsel = 1'b1; htrans = (i == 0) ? 2'd2 : 2'd3; hburst = 3'd3;
                hwrite = 1'b0; hsize = 3'd2; haddr = 32'(4 * i);
            end else begin
                hsel = 1'b0; htrans = 2'd0; hburst = 3'd0;
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
